// File: rtl/padbid_bus_pkg.sv
// Shared definitions for the PADBID pad-bus responder and its future initiator peer.
// Holds the bus state encoding and the turnaround counter sizing.
package padbid_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_TURN,
        ST_DRIVE,
        ST_RELEASE
    } state_t;

    localparam int TURN_MAX = 4;
    localparam int CNT_W    = $clog2(TURN_MAX);

    // The read/write flag always occupies the top pad bit.
    function automatic int rw_bit(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/padbid_turn_cnt.sv
// Loadable down-counter with a zero flag, used to time bus turnaround.
// Load takes priority over decrement; decrementing at zero is the caller's problem.
module padbid_turn_cnt
    import padbid_bus_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/padbid_bus_responder.sv
// Responder end of the half-duplex PADBID pad bus: decodes initiator commands,
// performs register writes, and drives read data back after a turnaround gap.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | bus released, waiting for a strobed command
// ST_WDATA   | pad_c carries write data this cycle
// ST_TURN    | initiator releasing the bus; counting turnaround cycles
// ST_DRIVE   | responder drives read data onto the pads for one cycle
// ST_RELEASE | bus undriven for one cycle before the next command
module padbid_bus_responder
    import padbid_bus_pkg::*;
#(
    parameter int W        = 8,
    parameter int ADDR_W   = 4,
    parameter int TURN_CYC = 1
)
(
    input  logic              CK,
    input  logic              RN,
    input  logic              strb,
    input  logic [W-1:0]      pad_c,
    output logic [W-1:0]      pad_i,
    output logic              pad_oen,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [W-1:0]      reg_wdata,
    output logic              reg_we,
    input  logic [W-1:0]      reg_rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int               RW_BIT  = rw_bit(W);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W-1:0]        r_pad_i;
    logic                r_pad_oen;
    logic [ADDR_W-1:0]   r_addr;
    logic [W-1:0]        r_wdata;
    logic                r_we;
    logic                r_busy;
    logic                r_proto_err;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_zero;
    logic                w_illegal;

    padbid_turn_cnt u_turn_cnt (
        .i_clk      (CK),
        .i_rst_n    (RN),
        .i_load     (w_cnt_load),
        .i_load_val (TURN_LD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // A strobe while the read is in flight is flagged but otherwise ignored.
    assign w_illegal = strb && (r_state inside {ST_TURN, ST_DRIVE, ST_RELEASE});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (strb) begin
                    if (pad_c[RW_BIT]) begin
                        w_state_nxt = ST_TURN;
                        w_cnt_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WDATA;
                    end
                end
            end
            ST_WDATA:   w_state_nxt = ST_IDLE;
            ST_TURN: begin
                if (w_cnt_zero) w_state_nxt = ST_DRIVE;
                else            w_cnt_dec   = 1'b1;
            end
            ST_DRIVE:   w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state     <= ST_IDLE;
            r_pad_i     <= '0;
            r_pad_oen   <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_we        <= 1'b0;
            r_proto_err <= w_illegal;
            if (r_state == ST_IDLE && strb) begin
                r_addr <= pad_c[ADDR_W-1:0];
            end
            if (r_state == ST_WDATA) begin
                r_wdata <= pad_c;
                r_we    <= 1'b1;
            end
            if (r_state == ST_TURN && w_cnt_zero) begin
                r_pad_i   <= reg_rdata;
                r_pad_oen <= 1'b0;
            end
            if (r_state == ST_DRIVE) begin
                r_pad_oen <= 1'b1;
            end
        end
    end

    assign pad_i     = r_pad_i;
    assign pad_oen   = r_pad_oen;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign busy      = r_busy;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_padbid_bus_responder.sv
// Bench for padbid_bus_responder: two instances (turnaround 1 and 3) share the
// same stimulus and are compared every cycle against a latency-based reference model.
module tb_padbid_bus_responder;

    localparam int W      = 8;
    localparam int ADDR_W = 4;

    logic             CK = 1'b0;
    logic             RN;
    logic             strb;
    logic [W-1:0]     pad_c;
    logic [W-1:0]     pi   [2];
    logic             oen  [2];
    logic [ADDR_W-1:0] ra  [2];
    logic [W-1:0]     wd   [2];
    logic             we   [2];
    logic [W-1:0]     rd   [2];
    logic             bsy  [2];
    logic             perr [2];
    logic [W-1:0]     mem  [16];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_drv  = 0;

    // Reference model: each transaction is tracked by its age in edges since the command.
    int               m_age  [2];
    logic             m_rd   [2];
    logic [ADDR_W-1:0] m_ad  [2];
    logic [W-1:0]     m_pi   [2];
    logic [W-1:0]     m_wd   [2];
    logic             m_oen  [2];
    logic             m_we   [2];
    logic             m_busy [2];
    logic             m_err  [2];

    always #5 CK = ~CK;

    assign rd[0] = mem[ra[0]];
    assign rd[1] = mem[ra[1]];

    padbid_bus_responder #(.W(W), .ADDR_W(ADDR_W), .TURN_CYC(1)) u_dut1 (
        .CK(CK), .RN(RN), .strb(strb), .pad_c(pad_c),
        .pad_i(pi[0]), .pad_oen(oen[0]), .reg_addr(ra[0]), .reg_wdata(wd[0]),
        .reg_we(we[0]), .reg_rdata(rd[0]), .busy(bsy[0]), .proto_err(perr[0])
    );

    padbid_bus_responder #(.W(W), .ADDR_W(ADDR_W), .TURN_CYC(3)) u_dut3 (
        .CK(CK), .RN(RN), .strb(strb), .pad_c(pad_c),
        .pad_i(pi[1]), .pad_oen(oen[1]), .reg_addr(ra[1]), .reg_wdata(wd[1]),
        .reg_we(we[1]), .reg_rdata(rd[1]), .busy(bsy[1]), .proto_err(perr[1])
    );

    function automatic int turn_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_age[k]  = 0;
        m_rd[k]   = 1'b0;
        m_ad[k]   = '0;
        m_pi[k]   = '0;
        m_wd[k]   = '0;
        m_oen[k]  = 1'b1;
        m_we[k]   = 1'b0;
        m_busy[k] = 1'b0;
        m_err[k]  = 1'b0;
    endtask

    task automatic model_step(input int k, input logic s, input logic [W-1:0] pc);
        m_we[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (m_age[k] == 0) begin
            if (s) begin
                m_ad[k]   = pc[ADDR_W-1:0];
                m_rd[k]   = pc[W-1];
                m_age[k]  = 1;
                m_busy[k] = 1'b1;
            end
        end else if (!m_rd[k]) begin
            m_wd[k]   = pc;
            m_we[k]   = 1'b1;
            m_age[k]  = 0;
            m_busy[k] = 1'b0;
        end else begin
            if (s) m_err[k] = 1'b1;
            if (m_age[k] == turn_of(k)) begin
                m_pi[k]  = mem[m_ad[k]];
                m_oen[k] = 1'b0;
            end
            if (m_age[k] == turn_of(k) + 1) m_oen[k] = 1'b1;
            if (m_age[k] == turn_of(k) + 2) begin
                m_age[k]  = 0;
                m_busy[k] = 1'b0;
            end else begin
                m_age[k]++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t%0d_pad_oen", turn_of(k)),   32'(oen[k]),  32'(m_oen[k]));
            chk($sformatf("t%0d_pad_i", turn_of(k)),     32'(pi[k]),   32'(m_pi[k]));
            chk($sformatf("t%0d_reg_addr", turn_of(k)),  32'(ra[k]),   32'(m_ad[k]));
            chk($sformatf("t%0d_reg_wdata", turn_of(k)), 32'(wd[k]),   32'(m_wd[k]));
            chk($sformatf("t%0d_reg_we", turn_of(k)),    32'(we[k]),   32'(m_we[k]));
            chk($sformatf("t%0d_busy", turn_of(k)),      32'(bsy[k]),  32'(m_busy[k]));
            chk($sformatf("t%0d_proto_err", turn_of(k)), 32'(perr[k]), 32'(m_err[k]));
        end
        if (oen[1] === 1'b0) n_drv++;
    endtask

    // Present inputs (called at the falling edge), clock them, update model, check.
    task automatic cyc(input logic s, input logic [W-1:0] pc);
        strb  = s;
        pad_c = pc;
        @(posedge CK);
        for (int k = 0; k < 2; k++) begin
            if (RN) model_step(k, s, pc);
            else    model_reset(k);
        end
        @(negedge CK);
        check_all();
    endtask

    initial begin
        RN    = 1'b0;
        strb  = 1'b0;
        pad_c = '0;
        for (int i = 0; i < 16; i++) mem[i] = W'($urandom);
        mem[9] = 8'h3C;
        model_reset(0);
        model_reset(1);
        @(negedge CK);

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) cyc(1'($urandom), W'($urandom));
        RN = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, W'($urandom));

        // Directed write: addr 5, data A7.
        cyc(1'b1, 8'h05);
        cyc(1'b0, 8'hA7);
        chk("wr_we_high", 32'(we[0]), 32'd1);
        chk("wr_wdata", 32'(wd[0]), 32'hA7);
        chk("wr_addr", 32'(ra[0]), 32'h5);
        chk("wr_busy_low", 32'(bsy[0]), 32'd0);
        cyc(1'b0, 8'h00);
        chk("wr_we_one_cycle", 32'(we[0]), 32'd0);

        // Directed read of address 9.
        cyc(1'b1, 8'h89);
        chk("rd_turn_oen", 32'(oen[0]), 32'd1);
        cyc(1'b0, 8'h00);
        chk("rd_drive_oen", 32'(oen[0]), 32'd0);
        chk("rd_drive_data", 32'(pi[0]), 32'h3C);
        cyc(1'b0, 8'h00);
        chk("rd_release_oen", 32'(oen[0]), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00);

        // Back-to-back reads of address 2, one strobe every 6 cycles.
        n_drv = 0;
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, 8'h82);
            for (int i = 0; i < 5; i++) cyc(1'b0, W'($urandom));
        end
        cyc(1'b0, 8'h00);
        chk("b2b_reads_served", 32'(n_drv), 32'd4);

        // Illegal strobes during TURN and DRIVE of the 3-cycle instance.
        cyc(1'b1, 8'h82);
        cyc(1'b1, 8'h8F);
        chk("ill_turn_err", 32'(perr[1]), 32'd1);
        chk("ill_turn_addr", 32'(ra[1]), 32'h2);
        cyc(1'b0, 8'h00);
        chk("ill_err_pulse", 32'(perr[1]), 32'd0);
        cyc(1'b0, 8'h00);
        chk("ill_drive_oen", 32'(oen[1]), 32'd0);
        cyc(1'b1, 8'h8F);
        chk("ill_drive_err", 32'(perr[1]), 32'd1);
        chk("ill_drive_addr", 32'(ra[1]), 32'h2);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00);

        // Reset asserted while the 1-cycle instance drives the bus.
        cyc(1'b1, 8'h89);
        cyc(1'b0, 8'h00);
        chk("mid_rd_driving", 32'(oen[0]), 32'd0);
        RN = 1'b0;
        #1;
        chk("mid_rd_async_oen", 32'(oen[0]), 32'd1);
        chk("mid_rd_async_busy", 32'(bsy[0]), 32'd0);
        model_reset(0);
        model_reset(1);
        @(negedge CK);
        cyc(1'b0, 8'h00);
        RN = 1'b1;
        cyc(1'b1, 8'h03);
        cyc(1'b0, 8'h5A);
        chk("post_rst_write", 32'(wd[0]), 32'h5A);

        // Randomized traffic, including illegal strobes.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
